// File: rtl/rs232c_tx_param.sv
// rtl/rs232c_tx_param.sv - parametrised RS-232C transmitter with input FIFO
//
// Frames: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// Bit period DIV = CLK_HZ/BAUD clocks. Host words queue in a FIFO_DEPTH-entry FIFO.
// Optional line break generator enabled by defining macro RS232C_BREAK_EN.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   din        - data word to queue
//   din_valid  - din is presented; accepted when din_ready is high
//   din_ready  - FIFO not full
//   break_req  - (RS232C_BREAK_EN only) request a line break from IDLE
//   tx         - registered serial output, idle high
//   busy       - frame/break on the line or FIFO non-empty
//   fifo_count - number of queued words

module rs232c_tx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
`ifdef RS232C_BREAK_EN
  input  logic                          break_req,
`endif
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
`ifdef RS232C_BREAK_EN
  localparam int FRAME_CLKS = (1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS) * DIV;
  localparam int BRK_W      = $clog2(FRAME_CLKS);
`endif

  if (DIV < 2) begin : g_div_chk
    $error("rs232c_tx_param: CLK_HZ/BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("rs232c_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("rs232c_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("rs232c_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_chk
    $error("rs232c_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef RS232C_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  // No full-bypass: a full FIFO refuses a word even if a pop happens this cycle.
  assign push  = din_valid && !full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- framer
  state_t               state;
  state_t               state_d;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_d;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;
  logic                 par_bit;
  logic                 par_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 bit_end;
`ifdef RS232C_BREAK_EN
  logic [BRK_W-1:0]     brk_cnt;
  logic [BRK_W-1:0]     brk_d;
`endif

  assign bit_end = (baud_cnt == CNT_W'(DIV - 1));

  // tx is registered from the next-state decode so the line changes on the
  // same edge the state does (start bit visible on the popping edge).
  always_comb begin
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    par_d   = par_bit;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef RS232C_BREAK_EN
    brk_d   = brk_cnt;
`endif
    case (state)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
`ifdef RS232C_BREAK_EN
        if (break_req) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
          brk_d   = '0;
        end else
`endif
        if (!empty) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr];
          par_d   = (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        baud_d = bit_end ? '0 : baud_cnt + CNT_W'(1);
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shreg[0];
        end
      end
      S_DATA: begin
        baud_d = bit_end ? '0 : baud_cnt + CNT_W'(1);
        if (bit_end) begin
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_cnt + 4'd1;
            shreg_d = shreg >> 1;
            tx_d    = shreg[1];
          end
        end
      end
      S_PARITY: begin
        baud_d = bit_end ? '0 : baud_cnt + CNT_W'(1);
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        baud_d = bit_end ? '0 : baud_cnt + CNT_W'(1);
        tx_d   = 1'b1;
        if (bit_end) begin
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_cnt + 4'd1;
          end
        end
      end
`ifdef RS232C_BREAK_EN
      // Counter saturates at one frame length; the break ends only once that
      // minimum has passed and the request has been dropped.
      S_BREAK: begin
        tx_d = 1'b0;
        if (brk_cnt == BRK_W'(FRAME_CLKS - 1)) begin
          if (!break_req) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
          end
        end else begin
          brk_d = brk_cnt + BRK_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
`ifdef RS232C_BREAK_EN
      brk_cnt  <= '0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      par_bit  <= par_d;
      tx_q     <= tx_d;
`ifdef RS232C_BREAK_EN
      brk_cnt  <= brk_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state != S_IDLE) || !empty;
  assign din_ready  = !full;
  assign fifo_count = count;

endmodule

// File: doc/rs232c_tx_param.md
Name: rs232c_tx_param

Overview:
Parametrised RS-232C serial transmitter that succeeds the fixed 8N1 transmitter.
- Generalised in data width, parity mode, stop-bit count and baud divisor.
- Adds a valid/ready input handshake backed by a small FIFO, so a host can queue bytes while a frame is being sent.
- Sits between on-chip logic and the board TX pin; output is idle-high, LSB first.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate. Bit period DIV = CLK_HZ/BAUD clocks, integer truncation (default 5208). DIV >= 2 is required; elaboration error otherwise.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- FIFO_DEPTH, 4, entries in the input FIFO; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active low.
- din  in  DATA_BITS  data word to send.
- din_valid  in  1  din is presented.
- din_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  high while a frame or break is on the line, or while the FIFO is non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued words.

Behaviour:
- Reset (rst_n=0), applied asynchronously, including mid-frame:
  - tx=1, busy=0, din_ready=1, fifo_count=0.
  - FIFO pointers, baud counter and bit counter are cleared; state is IDLE.
  - Any partial frame is abandoned; there is no resume after reset.
- Push: on a clk edge with din_valid && din_ready, din is written and fifo_count increments.
  - When the FIFO is full, din_ready=0 and din is ignored.
  - This holds even if a pop occurs in the same cycle; there is no full-bypass.
- Pop: happens only in IDLE with FIFO non-empty.
  - If a push and a pop occur in the same cycle, fifo_count is unchanged.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. If FIFO is non-empty, pop into the shift register, clear the baud counter and go to START. tx=0 is visible from the same edge.
  - START, DATA, PARITY and STOP each last exactly DIV clocks per bit.
  - The baud counter runs 0..DIV-1; each bit advances at count DIV-1.
  - DATA: DATA_BITS bits, LSB first.
  - PARITY: present only when PARITY!=0. Odd: tx = ~^data. Even: tx = ^data.
  - STOP: tx=1 for STOP_BITS*DIV clocks.
- Latency: a word pushed into an empty FIFO while in IDLE at edge N gives tx falling at edge N+1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * DIV clocks.
- Back-to-back frames: if the FIFO is non-empty when STOP ends, the next start bit begins at the following edge, with no idle gap beyond one clock.
- busy: falls on the edge at which the state returns to IDLE with the FIFO empty.

Optional Feature:
Macro RS232C_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit) and a BREAK state.
  - From IDLE, break_req=1 takes priority over a FIFO pop and enters BREAK with tx=0.
  - BREAK holds until break_req=0 AND at least one full frame length (formula above) has elapsed.
  - It then drives tx=1 for STOP_BITS*DIV clocks and returns to IDLE.
  - busy=1 throughout.
  - break_req asserted mid-frame is ignored until IDLE.
  - Pushes into the FIFO are still accepted during BREAK.
- Undefined: no break_req port and no BREAK state; behaviour is otherwise identical.

Test Plan:
- CLK_HZ=1600, BAUD=100 (DIV=16), 8N1; push 8'hA5 once -> tx low 1 clk after push, then bits 1,0,1,0,0,1,0,1 each 16 clks, stop high 16 clks; total 160 clks; busy falls at end.
- DATA_BITS=7, PARITY=1 (odd), STOP_BITS=2, DIV=16; push 7'h03 -> parity bit 1, stop high 32 clks; frame 176 clks.
- FIFO_DEPTH=4; hold din_valid with 5 words while a frame is active -> 4 accepted, din_ready=0 after 4th, fifo_count=4; frames then leave back-to-back with no gap.
- Assert rst_n=0 at 70 clks into a frame -> tx=1 immediately (asynchronously), fifo_count=0; after release, line stays idle until a new push.
- With RS232C_BREAK_EN, DIV=16, 8N1, break_req high for 20 clks -> tx low for 160 clks (min frame), then high 16 clks, then the queued byte is sent.
